// File: rtl/ochan_accumulator.sv
// ochan_accumulator
// Keeps one running signed sum per output channel, adding the sign-extended
// partial sums delivered by the compute engine. On the final input-channel beat
// of an output channel, the finished sum and its channel index are pushed into
// a small circular output FIFO. The FIFO drains through a valid/ready handshake.
//
// Build option: define OCHAN_ACC_RELU_EN to clamp negative finished sums to
// zero as they enter the FIFO. The accumulators always keep the raw sum.
module ochan_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_OCH    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*DATA_WIDTH-1:0]   psum,
  input  logic [7:0]                in_ch_sel,
  input  logic [7:0]                out_ch_sel,
  input  logic                      last_in_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic [7:0]                out_ch,
  output logic                      err_och
);

  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int OCW = (NUM_OCH > 1) ? $clog2(NUM_OCH) : 1;

  // Accumulator array, one signed sum per output channel
  logic signed [ACC_WIDTH-1:0] acc_r [NUM_OCH];

  // Output FIFO storage and bookkeeping
  logic [ACC_WIDTH-1:0] mem_data_r [FIFO_DEPTH];
  logic [7:0]           mem_ch_r   [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic                 err_och_r;

  // Datapath and handshake signals
  logic                        accept_s;
  logic                        in_range_s;
  logic [OCW-1:0]              oc_idx_s;
  logic signed [2*DATA_WIDTH-1:0] psum_sgn_s;
  logic signed [ACC_WIDTH-1:0] psum_ext_s;
  logic signed [ACC_WIDTH-1:0] acc_base_s;
  logic signed [ACC_WIDTH-1:0] next_sum_s;
  logic [ACC_WIDTH-1:0]        push_val_s;
  logic                        push_s;
  logic                        pop_s;
  logic                        out_valid_s;
  logic                        has_room_s;

  // Compute the next sum for the addressed channel and the FIFO push/pop strobes
  always_comb begin
    out_valid_s = 1'b0;
    has_room_s  = 1'b0;
    pop_s       = 1'b0;
    in_ready    = 1'b0;
    accept_s    = 1'b0;
    in_range_s  = 1'b0;
    oc_idx_s    = '0;
    psum_sgn_s  = '0;
    psum_ext_s  = '0;
    acc_base_s  = '0;
    next_sum_s  = '0;
    push_val_s  = '0;
    push_s      = 1'b0;

    out_valid_s = (count_r != {CW{1'b0}});
    has_room_s  = (count_r < CW'(FIFO_DEPTH));
    pop_s       = out_valid_s & out_ready;
    // A pop on this edge frees a slot, so a full FIFO can still take a last beat.
    in_ready    = rst_n & (has_room_s | pop_s);
    accept_s    = in_valid & in_ready;

    in_range_s  = ({1'b0, out_ch_sel} < 9'(NUM_OCH));
    oc_idx_s    = out_ch_sel[OCW-1:0];

    psum_sgn_s  = psum;
    psum_ext_s  = ACC_WIDTH'(psum_sgn_s);

    // Input channel 0 starts a fresh accumulation; out-of-range indices never read.
    if ((in_ch_sel == 8'd0) || !in_range_s) begin
      acc_base_s = '0;
    end else begin
      acc_base_s = acc_r[oc_idx_s];
    end
    next_sum_s = acc_base_s + psum_ext_s;

`ifdef OCHAN_ACC_RELU_EN
    if (next_sum_s[ACC_WIDTH-1]) begin
      push_val_s = '0;
    end else begin
      push_val_s = next_sum_s;
    end
`else
    push_val_s = next_sum_s;
`endif

    push_s = accept_s & in_range_s & last_in_ch;
  end

  // Accumulator update: write the next sum back for in-range accepted beats
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OCH; i++) begin
        acc_r[i] <= '0;
      end
    end else if (accept_s && in_range_s) begin
      acc_r[oc_idx_s] <= next_sum_s;
    end
  end

  // FIFO storage write: record finished sum and channel at the write pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_r[i] <= '0;
        mem_ch_r[i]   <= 8'd0;
      end
    end else if (push_s) begin
      mem_data_r[wr_ptr_r] <= push_val_s;
      mem_ch_r[wr_ptr_r]   <= out_ch_sel;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flag for beats addressed beyond the accumulator array
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_och_r <= 1'b0;
    end else if (accept_s && !in_range_s) begin
      err_och_r <= 1'b1;
    end
  end

  assign out_valid = out_valid_s;
  assign out_data  = mem_data_r[rd_ptr_r];
  assign out_ch    = mem_ch_r[rd_ptr_r];
  assign err_och   = err_och_r;

endmodule

// File: tb/tb_ochan_accumulator.sv
// Directed, table-driven bench for ochan_accumulator (default parameters).
module tb_ochan_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] psum;
  logic [7:0]  in_ch_sel;
  logic [7:0]  out_ch_sel;
  logic        last_in_ch;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_ch;
  logic        err_och;

  int checks;
  int failures;

`ifdef OCHAN_ACC_RELU_EN
  localparam logic [31:0] NEG5_EXP = 32'h0000_0000;
`else
  localparam logic [31:0] NEG5_EXP = 32'hFFFF_FFFB;
`endif

  ochan_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .psum       (psum),
    .in_ch_sel  (in_ch_sel),
    .out_ch_sel (out_ch_sel),
    .last_in_ch (last_in_ch),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .err_och    (err_och)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v;
    logic [15:0] ps;
    logic [7:0]  ic;
    logic [7:0]  oc;
    logic        last;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_ov;
    logic [31:0] exp_data;
    logic [7:0]  exp_ch;
    logic        exp_err;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] ps, input logic [7:0] ic,
                       input logic [7:0] oc, input logic last, input logic ordy);
    in_valid   = v;
    psum       = ps;
    in_ch_sel  = ic;
    out_ch_sel = oc;
    last_in_ch = last;
    out_ready  = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b1, 16'd1, 8'd0, 8'd0, 1'b1, 1'b1);

    // Reset held 3 cycles with a beat offered: nothing accepted
    for (int i = 0; i < 3; i++) begin
      #1;
      if (i > 0) chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_err", {31'd0, err_och}, 32'd0);
    end
    drive(1'b0, 16'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    //           v     psum       ic     oc     last  ordy  rdy   ov    data           ch     err
    tbl[0]  = '{1'b1, 16'd100,   8'd0, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,         8'd0, 1'b0};
    tbl[1]  = '{1'b1, 16'hFFE2,  8'd1, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,         8'd0, 1'b0};
    tbl[2]  = '{1'b1, 16'd7,     8'd2, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,         8'd0, 1'b0};
    tbl[3]  = '{1'b1, 16'd500,   8'd3, 8'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'd577,       8'd2, 1'b0};
    tbl[4]  = '{1'b0, 16'd0,     8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,         8'd0, 1'b0};
    tbl[5]  = '{1'b1, 16'h7FFF,  8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,         8'd0, 1'b0};
    tbl[6]  = '{1'b1, 16'h8000,  8'd0, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,         8'd0, 1'b0};
    tbl[7]  = '{1'b1, 16'h7FFF,  8'd1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'd65534,     8'd0, 1'b0};
    tbl[8]  = '{1'b1, 16'h8000,  8'd1, 8'd1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd65534,     8'd0, 1'b0};
    tbl[9]  = '{1'b0, 16'd0,     8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_0000, 8'd1, 1'b0};
    tbl[10] = '{1'b0, 16'd0,     8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,         8'd0, 1'b0};
    tbl[11] = '{1'b1, 16'hFFFB,  8'd0, 8'd5, 1'b1, 1'b1, 1'b1, 1'b1, NEG5_EXP,      8'd5, 1'b0};
    tbl[12] = '{1'b0, 16'd0,     8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,         8'd0, 1'b0};
    tbl[13] = '{1'b1, 16'd9,     8'd0, 8'd8, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0,         8'd0, 1'b1};
    tbl[14] = '{1'b0, 16'd0,     8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,         8'd0, 1'b1};
    tbl[15] = '{1'b1, 16'd1,     8'd1, 8'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'd578,       8'd2, 1'b1};
    tbl[16] = '{1'b1, 16'd0,     8'd1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'd65534,     8'd0, 1'b1};
    tbl[17] = '{1'b0, 16'd0,     8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,         8'd0, 1'b1};

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].ps, tbl[i].ic, tbl[i].oc, tbl[i].last, tbl[i].ordy);
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_rdy});
      tick();
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_ov});
      chk($sformatf("v%0d_err", i), {31'd0, err_och}, {31'd0, tbl[i].exp_err});
      if (tbl[i].exp_ov) begin
        chk($sformatf("v%0d_out_data", i), out_data, tbl[i].exp_data);
        chk($sformatf("v%0d_out_ch", i), {24'd0, out_ch}, {24'd0, tbl[i].exp_ch});
      end
    end

    // Backpressure: four single-beat channels fill the FIFO
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 16'(10 * (k + 1)), 8'd0, 8'(k), 1'b1, 1'b0);
      #1;
      chk($sformatf("bp_fill%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
      tick();
    end
    drive(1'b1, 16'd50, 8'd0, 8'd4, 1'b1, 1'b0);
    #1;
    chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bp_full_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_full_head", out_data, 32'd10);
    chk("bp_full_head_ch", {24'd0, out_ch}, 32'd0);
    // Full with the consumer ready: the fifth beat enters as the head leaves
    out_ready = 1'b1;
    #1;
    chk("bp_pop_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      #1;
      chk($sformatf("bp_drain%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_drain%0d_data", k), out_data, 32'(10 * (k + 1)));
      chk($sformatf("bp_drain%0d_ch", k), {24'd0, out_ch}, 32'(k));
      tick();
    end
    chk("bp_empty_valid", {31'd0, out_valid}, 32'd0);

    // Reset mid-accumulation with a queued output: everything discarded
    drive(1'b1, 16'd11, 8'd0, 8'd3, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'd6, 8'd0, 8'd6, 1'b1, 1'b0);
    tick();
    chk("mid_queued_valid", {31'd0, out_valid}, 32'd1);
    drive(1'b0, 16'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_err", {31'd0, err_och}, 32'd0);
    drive(1'b1, 16'd2, 8'd1, 8'd3, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("mid_resume_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_resume_data", out_data, 32'd2);
    chk("mid_resume_ch", {24'd0, out_ch}, 32'd3);
    tick();
    chk("mid_final_valid", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
